// File: rtl/audio_sample_player.sv
// Playback stage: pops one byte from the sample FIFO per sample tick, applies a
// 17-step volume scale about midscale and presents the result to the PWM stage.
// Primes the FIFO before playing and emits silence and re-primes on underrun.
module audio_sample_player #(
  parameter int unsigned START_LEVEL = 512,
  parameter int unsigned MIDSCALE    = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sample_tick,
  input  logic [4:0]  volume,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  input  logic [10:0] fifo_data_count,
  output logic        fifo_rd_en,
  output logic [7:0]  music_data,
  output logic        sample_valid,
  output logic        playing,
  output logic        underrun,
  output logic [15:0] underrun_count
);

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 5;
  localparam int unsigned CW = 11;
  localparam int unsigned UW = 16;
  localparam int unsigned PW = 14;

  localparam logic [DW-1:0]        MID_CODE  = DW'(MIDSCALE);
  localparam logic signed [DW:0]   MID_S9    = (DW+1)'(MIDSCALE);
  localparam logic [CW-1:0]        START_CNT = CW'(START_LEVEL);
  localparam logic [VW-1:0]        UNITY     = VW'(16);
  localparam logic [UW-1:0]        CNT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    WAIT_TICK,
    READ,
    CAPTURE
  } state_t;

  state_t             state, state_nxt;
  logic               tick_pending, pending_nxt;
  logic               abort, abort_nxt;
  logic [DW-1:0]      music_nxt;
  logic               valid_nxt;
  logic               underrun_nxt;
  logic [UW-1:0]      count_nxt;
  logic               rd_nxt;
  logic               playing_nxt;

  logic signed [DW:0]   diff;
  logic [VW-1:0]        gain;
  logic signed [PW-1:0] prod;
  logic [DW-1:0]        scaled;

  // Volume scaling about midscale; result always lands in 0..255
  always_comb begin
    diff   = $signed({1'b0, fifo_dout}) - MID_S9;
    gain   = (volume > UNITY) ? UNITY : volume;
    prod   = PW'(diff) * $signed({(PW-VW)'(0), gain});
    scaled = DW'((prod >>> 4) + PW'(MID_S9));
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt    = state;
    pending_nxt  = tick_pending;
    abort_nxt    = abort;
    music_nxt    = music_data;
    valid_nxt    = 1'b0;
    underrun_nxt = 1'b0;
    count_nxt    = underrun_count;

    case (state)
      IDLE: begin
        if (enable) state_nxt = PRIME;
      end
      PRIME: begin
        if (!enable)                           state_nxt = IDLE;
        else if (fifo_data_count >= START_CNT) state_nxt = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (sample_tick || tick_pending) begin
          pending_nxt = 1'b0;
          if (fifo_empty) begin
            underrun_nxt = 1'b1;
            music_nxt    = MID_CODE;
            if (underrun_count != CNT_MAX) count_nxt = underrun_count + UW'(1);
            state_nxt    = PRIME;
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ: begin
        if (sample_tick) pending_nxt = 1'b1;
        if (!enable)     abort_nxt   = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (sample_tick) pending_nxt = 1'b1;
        if (abort || !enable) begin
          state_nxt = IDLE;
        end else begin
          music_nxt = scaled;
          valid_nxt = 1'b1;
          state_nxt = WAIT_TICK;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Being in or entering IDLE always means silence and no stale tick/abort
    if (state_nxt == IDLE) begin
      music_nxt   = MID_CODE;
      pending_nxt = 1'b0;
      abort_nxt   = 1'b0;
    end

    rd_nxt      = (state_nxt == READ);
    playing_nxt = (state_nxt == WAIT_TICK) || (state_nxt == READ) ||
                  (state_nxt == CAPTURE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      tick_pending   <= 1'b0;
      abort          <= 1'b0;
      fifo_rd_en     <= 1'b0;
      music_data     <= MID_CODE;
      sample_valid   <= 1'b0;
      playing        <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      state          <= state_nxt;
      tick_pending   <= pending_nxt;
      abort          <= abort_nxt;
      fifo_rd_en     <= rd_nxt;
      music_data     <= music_nxt;
      sample_valid   <= valid_nxt;
      playing        <= playing_nxt;
      underrun       <= underrun_nxt;
      underrun_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_audio_sample_player.sv
// Directed bench for audio_sample_player with a behavioural standard FIFO.
module tb_audio_sample_player;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sample_tick;
  logic [4:0]  volume;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic [10:0] fifo_data_count;
  logic        fifo_rd_en;
  logic [7:0]  music_data;
  logic        sample_valid;
  logic        playing;
  logic        underrun;
  logic [15:0] underrun_count;

  audio_sample_player dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .sample_tick     (sample_tick),
    .volume          (volume),
    .fifo_dout       (fifo_dout),
    .fifo_empty      (fifo_empty),
    .fifo_data_count (fifo_data_count),
    .fifo_rd_en      (fifo_rd_en),
    .music_data      (music_data),
    .sample_valid    (sample_valid),
    .playing         (playing),
    .underrun        (underrun),
    .underrun_count  (underrun_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sample;
    logic [4:0] vol;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[16];
  logic [7:0] fifo_q[$];
  logic       rd_prev;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         rd_seen  = 0;
  int         sv_seen  = 0;
  logic [7:0] rd_pat, sv_pat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sync_flags();
    fifo_empty      = (fifo_q.size() == 0);
    fifo_data_count = 11'(fifo_q.size());
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    sync_flags();
  endtask

  // One clock: drive tick, let the FIFO model respond, sample at the falling edge
  task automatic cyc(input logic tk);
    sample_tick = tk;
    rd_prev     = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd_prev && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    sync_flags();
    @(negedge clk);
    sample_tick = 1'b0;
    rd_seen += int'(fifo_rd_en);
    sv_seen += int'(sample_valid);
  endtask

  task automatic do_sample();
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'hFF, 5'd16, 8'hFF};
    vecs[1]  = '{8'h00, 5'd16, 8'h00};
    vecs[2]  = '{8'hC0, 5'd16, 8'hC0};
    vecs[3]  = '{8'hFF, 5'd8,  8'hBF};
    vecs[4]  = '{8'h00, 5'd8,  8'h40};
    vecs[5]  = '{8'hC0, 5'd8,  8'hA0};
    vecs[6]  = '{8'hFF, 5'd0,  8'h80};
    vecs[7]  = '{8'h00, 5'd0,  8'h80};
    vecs[8]  = '{8'hC0, 5'd0,  8'h80};
    vecs[9]  = '{8'hFF, 5'd31, 8'hFF};
    vecs[10] = '{8'h00, 5'd31, 8'h00};
    vecs[11] = '{8'hC0, 5'd31, 8'hC0};
    vecs[12] = '{8'h81, 5'd4,  8'h80};
    vecs[13] = '{8'h7F, 5'd4,  8'h7F};
    vecs[14] = '{8'h00, 5'd1,  8'h78};
    vecs[15] = '{8'hFF, 5'd15, 8'hF7};

    reset_n     = 1'b0;
    enable      = 1'b0;
    sample_tick = 1'b0;
    volume      = 5'd16;
    fifo_dout   = 8'h00;
    sync_flags();
    @(negedge clk);
    @(negedge clk);
    check("reset music_data", 32'(music_data), 32'h80);
    check("reset rd_en", 32'(fifo_rd_en), 32'h0);
    check("reset sample_valid", 32'(sample_valid), 32'h0);
    check("reset playing", 32'(playing), 32'h0);
    check("reset underrun", 32'(underrun), 32'h0);
    check("reset count", 32'(underrun_count), 32'h0);
    reset_n = 1'b1;
    cyc(1'b0);

    // T1: prime gate at 511 bytes, then release at 512
    push(8'h3C);
    for (int i = 1; i < 511; i++) push(8'(i));
    enable  = 1'b1;
    rd_seen = 0;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    check("t1 no rd while priming", 32'(rd_seen), 32'h0);
    check("t1 silent while priming", 32'(music_data), 32'h80);
    check("t1 not playing", 32'(playing), 32'h0);
    push(8'hFF);
    cyc(1'b0);
    check("t1 playing after prime", 32'(playing), 32'h1);
    cyc(1'b1);
    check("t1 rd_en at T+1", 32'(fifo_rd_en), 32'h1);
    cyc(1'b0);
    check("t1 rd_en low at T+2", 32'(fifo_rd_en), 32'h0);
    check("t1 no valid at T+2", 32'(sample_valid), 32'h0);
    cyc(1'b0);
    check("t1 valid at T+3", 32'(sample_valid), 32'h1);
    check("t1 music at T+3", 32'(music_data), 32'h3C);

    // T3: drain the remaining 511 bytes, then tick 513 underruns
    sv_seen = 0;
    for (int i = 0; i < 511; i++) do_sample();
    check("t3 drained samples", 32'(sv_seen), 32'd511);
    check("t3 last sample", 32'(music_data), 32'hFF);
    cyc(1'b1);
    check("t3 underrun pulse", 32'(underrun), 32'h1);
    check("t3 silence", 32'(music_data), 32'h80);
    check("t3 count", 32'(underrun_count), 32'h1);
    check("t3 not playing", 32'(playing), 32'h0);
    check("t3 no rd", 32'(fifo_rd_en), 32'h0);
    cyc(1'b0);
    check("t3 underrun one clk", 32'(underrun), 32'h0);
    rd_seen = 0;
    cyc(1'b1);
    cyc(1'b0);
    check("t3 back in prime", 32'(rd_seen), 32'h0);
    enable = 1'b0;
    cyc(1'b0);
    cyc(1'b0);

    // T2: volume scaling table
    for (int i = 0; i < 16; i++) push(vecs[i].sample);
    for (int i = 0; i < 496; i++) push(8'(16 + i));
    enable = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    for (int i = 0; i < 16; i++) begin
      volume = vecs[i].vol;
      do_sample();
      check($sformatf("t2 vec%0d music", i), 32'(music_data), 32'(vecs[i].exp));
      check($sformatf("t2 vec%0d valid", i), 32'(sample_valid), 32'h1);
    end
    volume = 5'd16;

    // T4: tick at T and T+1 -> second served right after return
    for (int i = 0; i < 8; i++) begin
      cyc((i < 2) ? 1'b1 : 1'b0);
      rd_pat[i] = fifo_rd_en;
      sv_pat[i] = sample_valid;
    end
    check("t4 rd pattern", 32'(rd_pat), 32'h09);
    check("t4 valid pattern", 32'(sv_pat), 32'h24);
    check("t4 music", 32'(music_data), 32'h11);

    // T4b: a third tick while one is already pending is dropped
    rd_seen = 0;
    sv_seen = 0;
    for (int i = 0; i < 10; i++) cyc((i < 3) ? 1'b1 : 1'b0);
    check("t4b pops", 32'(rd_seen), 32'h2);
    check("t4b valids", 32'(sv_seen), 32'h2);
    check("t4b music", 32'(music_data), 32'h13);

    // T5: drop enable in the READ cycle
    rd_seen = 0;
    sv_seen = 0;
    cyc(1'b1);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b0);
    check("t5 one pop", 32'(rd_seen), 32'h1);
    check("t5 no valid", 32'(sv_seen), 32'h0);
    check("t5 silence", 32'(music_data), 32'h80);
    check("t5 idle", 32'(playing), 32'h0);

    // T6: async reset in the middle of CAPTURE
    for (int i = 0; i < 30; i++) push(8'hA5);
    enable = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    check("t6 playing", 32'(playing), 32'h1);
    check("t6 count held", 32'(underrun_count), 32'h1);
    cyc(1'b1);
    cyc(1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 async music", 32'(music_data), 32'h80);
    check("t6 async valid", 32'(sample_valid), 32'h0);
    check("t6 async playing", 32'(playing), 32'h0);
    check("t6 async rd", 32'(fifo_rd_en), 32'h0);
    check("t6 async underrun", 32'(underrun), 32'h0);
    check("t6 async count", 32'(underrun_count), 32'h0);
    @(negedge clk);
    enable  = 1'b0;
    reset_n = 1'b1;
    sv_seen = 0;
    cyc(1'b0);
    cyc(1'b0);
    check("t6 byte discarded", 32'(sv_seen), 32'h0);
    check("t6 music after", 32'(music_data), 32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
